ps2_key_decoder: RTL and testbench

- Upstream input stage of the game top level.
- Receives raw PS/2 keyboard clock/data, deserialises 11-bit frames and tracks make/break/extended prefixes.
- Drives held-direction levels (player movement, scroll/obstacle stepping) and one-shot start/continue pulses consumed by the game FSM.
- Replaces the ad-hoc keyboard front end with a filtered, parity-checked, watchdog-protected receiver.

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_rx_frame.sv | 143 ++++++++++++++
 rtl/ps2_key_decoder.sv | 125 ++++++++++++
 tb/tb_ps2_key_decoder.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard front end: scancodes, receiver
// state encoding and the bit positions of the held-direction outputs.
package ps2_pkg;

    // Prefix bytes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    // Arrow keys (only meaningful after an SC_EXT prefix)
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // Plain keys
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    // Letter aliases for the arrows
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;

    // Bit positions inside the btns vector
    localparam int BTN_UP    = 3;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_RIGHT = 0;

    // Frame receiver states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: two-flop synchronisers, a glitch filter on the
// keyboard clock, an 11-bit frame deserialiser with odd-parity and stop-bit
// checking, and a watchdog that abandons a frame if the keyboard clock stalls.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ps2Clk,
    input  logic       i_ps2Data,
    output logic [7:0] o_byte,
    output logic       o_valid,
    output logic       o_err
);

    localparam int TIMEOUT_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;
    localparam int TCW         = $clog2(TIMEOUT_CYC + 1);
    localparam int FCW         = $clog2(FILTER_LEN + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] WDOG_LAST = TCW'(TIMEOUT_CYC - 1);

    logic           r_clkSync1;
    logic           r_clkSync2;
    logic           r_datSync1;
    logic           r_datSync2;
    logic           r_filtClk;
    logic           r_filtClkDly;
    logic [FCW-1:0] r_filtCnt;
    logic           w_fall;

    rx_state_t      r_state;
    logic [2:0]     r_bitCnt;
    logic [7:0]     r_shift;
    logic           r_parity;
    logic [7:0]     r_byte;
    logic           r_valid;
    logic           r_err;
    logic [TCW-1:0] r_wdog;

    // Bring both raw lines into the clock domain; idle PS/2 lines are high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clkSync1 <= 1'b1;
            r_clkSync2 <= 1'b1;
            r_datSync1 <= 1'b1;
            r_datSync2 <= 1'b1;
        end else begin
            r_clkSync1 <= i_ps2Clk;
            r_clkSync2 <= r_clkSync1;
            r_datSync1 <= i_ps2Data;
            r_datSync2 <= r_datSync1;
        end
    end

    // Filtered clock only follows the synced clock after a run of identical samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filtClk    <= 1'b1;
            r_filtClkDly <= 1'b1;
            r_filtCnt    <= '0;
        end else begin
            r_filtClkDly <= r_filtClk;
            if (r_clkSync2 == r_filtClk) begin
                r_filtCnt <= '0;
            end else if (r_filtCnt == FILT_LAST) begin
                r_filtClk <= r_clkSync2;
                r_filtCnt <= '0;
            end else begin
                r_filtCnt <= r_filtCnt + FCW'(1);
            end
        end
    end

    assign w_fall = r_filtClkDly & ~r_filtClk;

    // Frame deserialiser and watchdog; byte/valid/err are registered here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_bitCnt <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_byte   <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_wdog   <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            if (w_fall) begin
                r_wdog <= '0;
                case (r_state)
                    IDLE: begin
                        if (!r_datSync2) begin
                            r_state  <= DATA;
                            r_bitCnt <= '0;
                        end
                    end
                    DATA: begin
                        r_shift  <= {r_datSync2, r_shift[7:1]};
                        r_bitCnt <= r_bitCnt + 3'd1;
                        if (r_bitCnt == 3'd7) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_parity <= r_datSync2;
                        r_state  <= STOP;
                    end
                    STOP: begin
                        if (r_datSync2 && (^{r_shift, r_parity})) begin
                            r_byte  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_state != IDLE) begin
                if (r_wdog == WDOG_LAST) begin
                    r_state <= IDLE;
                    r_err   <= 1'b1;
                    r_wdog  <= '0;
                end else begin
                    r_wdog <= r_wdog + TCW'(1);
                end
            end else begin
                r_wdog <= '0;
            end
        end
    end

    assign o_byte  = r_byte;
    assign o_valid = r_valid;
    assign o_err   = r_err;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder for the game top level. Receives frames through
// ps2_rx_frame, tracks the E0/F0 prefixes and turns arrow keys into held
// direction levels and Space/Enter into one-shot pulses.
// Build option: define WASD_EN to make W/A/S/D alias the arrow keys.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [3:0] btns,
    output logic       continue_btn,
    output logic       start_btn,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_err
);

    logic [7:0] w_byte;
    logic       w_valid;
    logic       w_err;

    logic       r_ext;
    logic       r_brk;
    logic [3:0] r_arrowHeld;
`ifdef WASD_EN
    logic [3:0] r_letterHeld;
`endif
    logic       r_spaceHeld;
    logic       r_enterHeld;
    logic       r_continue;
    logic       r_start;

    ps2_rx_frame #(
        .CLK_HZ     (CLK_HZ),
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .i_ps2Clk  (PS2_CLK),
        .i_ps2Data (PS2_DATA),
        .o_byte    (w_byte),
        .o_valid   (w_valid),
        .o_err     (w_err)
    );

    // Prefix tracking and key state; a rejected frame never reaches this block
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_arrowHeld  <= '0;
`ifdef WASD_EN
            r_letterHeld <= '0;
`endif
            r_spaceHeld  <= 1'b0;
            r_enterHeld  <= 1'b0;
            r_continue   <= 1'b0;
            r_start      <= 1'b0;
        end else begin
            r_continue <= 1'b0;
            r_start    <= 1'b0;
            if (w_valid) begin
                if (w_byte == SC_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_byte == SC_BREAK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (r_ext) begin
                        case (w_byte)
                            SC_UP:    r_arrowHeld[BTN_UP]    <= ~r_brk;
                            SC_DOWN:  r_arrowHeld[BTN_DOWN]  <= ~r_brk;
                            SC_LEFT:  r_arrowHeld[BTN_LEFT]  <= ~r_brk;
                            SC_RIGHT: r_arrowHeld[BTN_RIGHT] <= ~r_brk;
                            default:  ;
                        endcase
                    end else begin
                        case (w_byte)
                            SC_SPACE: begin
                                r_spaceHeld <= ~r_brk;
                                if (!r_brk && !r_spaceHeld) begin
                                    r_continue <= 1'b1;
                                end
                            end
                            SC_ENTER: begin
                                r_enterHeld <= ~r_brk;
                                if (!r_brk && !r_enterHeld) begin
                                    r_start <= 1'b1;
                                end
                            end
`ifdef WASD_EN
                            SC_W: r_letterHeld[BTN_UP]    <= ~r_brk;
                            SC_S: r_letterHeld[BTN_DOWN]  <= ~r_brk;
                            SC_A: r_letterHeld[BTN_LEFT]  <= ~r_brk;
                            SC_D: r_letterHeld[BTN_RIGHT] <= ~r_brk;
`endif
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

`ifdef WASD_EN
    assign btns = r_arrowHeld | r_letterHeld;
`else
    assign btns = r_arrowHeld;
`endif

    assign continue_btn = r_continue;
    assign start_btn    = r_start;
    assign scan_code    = w_byte;
    assign scan_valid   = w_valid;
    assign frame_err    = w_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed testbench for ps2_key_decoder. Drives bit-level PS/2 frames and
// compares outputs and pulse counts against hand-computed expectations.
// Build option: define WASD_EN to exercise the letter aliases.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

    localparam int CLK_HZ     = 1000000;
    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT_US = 1000;
    localparam int HALF       = 20;

    logic       clk;
    logic       rst;
    logic       ps2Clk;
    logic       ps2Data;
    logic [3:0] btns;
    logic       continueBtn;
    logic       startBtn;
    logic [7:0] scanCode;
    logic       scanValid;
    logic       frameErr;

    int checkCount;
    int failCount;

    int         validCount;
    int         valid29Count;
    int         continueCount;
    int         startCount;
    int         errCount;
    logic [7:0] lastCode;
    logic [3:0] btnsAtValid;
    logic [3:0] btnsAfterValid;
    bit         pendingAfter;

    ps2_key_decoder #(
        .CLK_HZ     (CLK_HZ),
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_US (TIMEOUT_US)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PS2_CLK      (ps2Clk),
        .PS2_DATA     (ps2Data),
        .btns         (btns),
        .continue_btn (continueBtn),
        .start_btn    (startBtn),
        .scan_code    (scanCode),
        .scan_valid   (scanValid),
        .frame_err    (frameErr)
    );

    // System clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count pulses and capture btns on and after each accepted byte
    always @(negedge clk) begin
        if (scanValid) begin
            validCount++;
            lastCode    = scanCode;
            btnsAtValid = btns;
            pendingAfter = 1'b1;
            if (scanCode == 8'h29) valid29Count++;
        end else if (pendingAfter) begin
            btnsAfterValid = btns;
            pendingAfter   = 1'b0;
        end
        if (continueBtn) continueCount++;
        if (startBtn)    startCount++;
        if (frameErr)    errCount++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] makeFrame(input logic [7:0] b, input logic badParity);
        logic p;
        p = badParity ? (^b) : ~(^b);
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic sendBits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2Data = bits[i];
            waitCycles(HALF);
            ps2Clk = 1'b0;
            waitCycles(HALF);
            ps2Clk = 1'b1;
        end
        ps2Data = 1'b1;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic badParity);
        sendBits(makeFrame(b, badParity), 11);
        waitCycles(2 * HALF);
    endtask

    task automatic test_reset;
        rst     = 1'b0;
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        waitCycles(5);
        checkCount++;
        if (btns !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL reset_btns got=%b want=0000", btns);
        end
        checkCount++;
        if (scanCode !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL reset_scan_code got=%h want=00", scanCode);
        end
        checkCount++;
        if ({scanValid, frameErr, continueBtn, startBtn} !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL reset_pulses got=%b want=0000",
                     {scanValid, frameErr, continueBtn, startBtn});
        end
        rst = 1'b1;
        waitCycles(5);
    endtask

    task automatic test_arrow_up;
        int v0;
        v0 = validCount;
        sendByte(8'hE0, 1'b0);
        sendByte(8'hE0, 1'b0);
        sendByte(8'h75, 1'b0);
        checkCount++;
        if (validCount - v0 !== 3) begin
            failCount++;
            $display("[TB] FAIL up_valid_count got=%0d want=3", validCount - v0);
        end
        checkCount++;
        if (lastCode !== 8'h75) begin
            failCount++;
            $display("[TB] FAIL up_scan_code got=%h want=75", lastCode);
        end
        checkCount++;
        if (btnsAtValid !== 4'b0000 || btnsAfterValid !== 4'b1000) begin
            failCount++;
            $display("[TB] FAIL up_latency got=%b/%b want=0000/1000", btnsAtValid, btnsAfterValid);
        end
        sendByte(8'hE0, 1'b0);
        sendByte(8'hF0, 1'b0);
        sendByte(8'h75, 1'b0);
        checkCount++;
        if (btns !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL up_release got=%b want=0000", btns);
        end
    endtask

    task automatic test_typematic_space;
        int c0;
        int v0;
        c0 = continueCount;
        v0 = valid29Count;
        sendByte(8'h29, 1'b0);
        sendByte(8'h29, 1'b0);
        sendByte(8'hF0, 1'b0);
        sendByte(8'h29, 1'b0);
        checkCount++;
        if (continueCount - c0 !== 1) begin
            failCount++;
            $display("[TB] FAIL space_pulses got=%0d want=1", continueCount - c0);
        end
        checkCount++;
        if (valid29Count - v0 !== 3) begin
            failCount++;
            $display("[TB] FAIL space_valid got=%0d want=3", valid29Count - v0);
        end
        sendByte(8'h29, 1'b0);
        checkCount++;
        if (continueCount - c0 !== 2) begin
            failCount++;
            $display("[TB] FAIL space_repress got=%0d want=2", continueCount - c0);
        end
        sendByte(8'hF0, 1'b0);
        sendByte(8'h29, 1'b0);
    endtask

    task automatic test_parity_error;
        int v0;
        int e0;
        int s0;
        v0 = validCount;
        e0 = errCount;
        s0 = startCount;
        sendByte(8'h5A, 1'b1);
        checkCount++;
        if (errCount - e0 !== 1) begin
            failCount++;
            $display("[TB] FAIL parity_err got=%0d want=1", errCount - e0);
        end
        checkCount++;
        if (validCount - v0 !== 0 || startCount - s0 !== 0) begin
            failCount++;
            $display("[TB] FAIL parity_reject got=valid%0d/start%0d want=0/0",
                     validCount - v0, startCount - s0);
        end
        sendByte(8'h5A, 1'b0);
        checkCount++;
        if (startCount - s0 !== 1 || lastCode !== 8'h5A) begin
            failCount++;
            $display("[TB] FAIL enter_start got=%0d/%h want=1/5a", startCount - s0, lastCode);
        end
        sendByte(8'hF0, 1'b0);
        sendByte(8'h5A, 1'b0);
    endtask

    task automatic test_timeout;
        int v0;
        int e0;
        int c0;
        v0 = validCount;
        e0 = errCount;
        c0 = continueCount;
        sendBits(makeFrame(8'h29, 1'b0), 5);
        waitCycles(1200);
        checkCount++;
        if (errCount - e0 !== 1 || validCount - v0 !== 0) begin
            failCount++;
            $display("[TB] FAIL timeout_err got=err%0d/valid%0d want=1/0",
                     errCount - e0, validCount - v0);
        end
        sendByte(8'h29, 1'b0);
        checkCount++;
        if (validCount - v0 !== 1 || lastCode !== 8'h29 || continueCount - c0 !== 1) begin
            failCount++;
            $display("[TB] FAIL timeout_recover got=valid%0d/%h/cont%0d want=1/29/1",
                     validCount - v0, lastCode, continueCount - c0);
        end
        sendByte(8'hF0, 1'b0);
        sendByte(8'h29, 1'b0);
    endtask

    task automatic test_bad_start;
        int v0;
        int e0;
        v0 = validCount;
        e0 = errCount;
        sendBits(11'h001, 1);
        waitCycles(2 * HALF);
        checkCount++;
        if (errCount - e0 !== 0 || validCount - v0 !== 0) begin
            failCount++;
            $display("[TB] FAIL bad_start got=err%0d/valid%0d want=0/0",
                     errCount - e0, validCount - v0);
        end
        sendByte(8'h16, 1'b0);
        checkCount++;
        if (lastCode !== 8'h16 || btns !== 4'b0000 || errCount - e0 !== 0) begin
            failCount++;
            $display("[TB] FAIL bad_start_next got=%h/%b/err%0d want=16/0000/0",
                     lastCode, btns, errCount - e0);
        end
    endtask

    task automatic test_back_to_back;
        sendByte(8'hE0, 1'b0);
        sendByte(8'h6B, 1'b0);
        sendByte(8'hE0, 1'b0);
        sendByte(8'h74, 1'b0);
        checkCount++;
        if (btns !== 4'b0011) begin
            failCount++;
            $display("[TB] FAIL left_right_held got=%b want=0011", btns);
        end
        sendBits(makeFrame(8'h75, 1'b0), 5);
        rst = 1'b0;
        #1;
        checkCount++;
        if (btns !== 4'b0000 || scanCode !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL reset_mid_frame got=%b/%h want=0000/00", btns, scanCode);
        end
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        waitCycles(3);
        rst = 1'b1;
        waitCycles(5);
        sendByte(8'hE0, 1'b0);
        sendByte(8'h75, 1'b0);
        checkCount++;
        if (btns !== 4'b1000) begin
            failCount++;
            $display("[TB] FAIL after_reset_up got=%b want=1000", btns);
        end
        sendByte(8'hE0, 1'b0);
        sendByte(8'hF0, 1'b0);
        sendByte(8'h75, 1'b0);
    endtask

`ifdef WASD_EN
    task automatic test_wasd;
        sendByte(8'h1D, 1'b0);
        sendByte(8'hE0, 1'b0);
        sendByte(8'h75, 1'b0);
        sendByte(8'hF0, 1'b0);
        sendByte(8'h1D, 1'b0);
        checkCount++;
        if (btns !== 4'b1000) begin
            failCount++;
            $display("[TB] FAIL wasd_overlap got=%b want=1000", btns);
        end
        sendByte(8'hE0, 1'b0);
        sendByte(8'hF0, 1'b0);
        sendByte(8'h75, 1'b0);
        checkCount++;
        if (btns !== 4'b0000) begin
            failCount++;
            $display("[TB] FAIL wasd_release got=%b want=0000", btns);
        end
        sendByte(8'h1C, 1'b0);
        checkCount++;
        if (btns !== 4'b0010) begin
            failCount++;
            $display("[TB] FAIL wasd_left got=%b want=0010", btns);
        end
        sendByte(8'hF0, 1'b0);
        sendByte(8'h1C, 1'b0);
    endtask
`else
    task automatic test_unmapped_letters;
        sendByte(8'h1D, 1'b0);
        checkCount++;
        if (btns !== 4'b0000 || lastCode !== 8'h1D) begin
            failCount++;
            $display("[TB] FAIL letter_unmapped got=%b/%h want=0000/1d", btns, lastCode);
        end
    endtask
`endif

    initial begin
        checkCount    = 0;
        failCount     = 0;
        validCount    = 0;
        valid29Count  = 0;
        continueCount = 0;
        startCount    = 0;
        errCount      = 0;
        lastCode      = 8'h00;
        btnsAtValid   = 4'h0;
        btnsAfterValid = 4'h0;
        pendingAfter  = 1'b0;

        test_reset();
        test_arrow_up();
        test_typematic_space();
        test_parity_error();
        test_timeout();
        test_bad_start();
        test_back_to_back();
`ifdef WASD_EN
        test_wasd();
`else
        test_unmapped_letters();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
